// File: rtl/dmem_pkg.sv
// Shared constants, FSM state type and counter sizing helper for the data-memory stage.
package dmem_pkg;

   localparam int DMEM_DATA_W  = 32;
   localparam int DMEM_DEPTH   = 32;
   localparam int DMEM_LATENCY = 2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } dmem_state_t;

   // The counter only ever holds LATENCY-2, but it keeps at least one bit so LATENCY=1 still elaborates.
   function automatic int dmem_cnt_width(input int latency);
      return (latency > 2) ? $clog2(latency) : 1;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data storage: combinational read port, synchronous write port.
module dmem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         r_mem[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = r_mem[addr_i];

endmodule

// File: rtl/dmem_stage.sv
// Pipeline data-memory stage: multi-cycle word access with stall/done handshake.
// Optional DMEM_MISALIGN_CHECK_EN flags and suppresses accesses with addr_i[1:0] != 0.
module dmem_stage
   import dmem_pkg::*;
#(
   parameter int DATA_W  = DMEM_DATA_W,
   parameter int DEPTH   = DMEM_DEPTH,
   parameter int LATENCY = DMEM_LATENCY
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic [31:0]       addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              stall_o,
   output logic              done_o,
   output logic              err_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = dmem_cnt_width(LATENCY);
   localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

   dmem_state_t       r_state;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_req;
   logic              w_final;
   logic              w_misalign;
   logic              w_we;
   logic [IDX_W-1:0]  w_idx;
   logic [DATA_W-1:0] w_rd_data;
   logic              w_unused_addr;

   assign w_req = mem_read_i | mem_write_i;
   assign w_idx = addr_i[2 +: IDX_W];
   assign w_unused_addr = ^{addr_i[31:2+IDX_W], addr_i[1:0]};

`ifdef DMEM_MISALIGN_CHECK_EN
   assign w_misalign = |addr_i[1:0];
`else
   assign w_misalign = 1'b0;
`endif

   // A cycle under reset is never final, so a reset coinciding with the closing edge commits nothing.
   always_comb begin
      w_final = 1'b0;
      if (!rst_i && w_req) begin
         if (r_state == ST_BUSY) begin
            w_final = (r_cnt == '0);
         end else begin
            w_final = (LATENCY == 1);
         end
      end
   end

   assign stall_o = !rst_i && w_req && !w_final;
   assign done_o  = w_final;
   assign err_o   = w_final & w_misalign;
   assign w_we    = w_final & mem_write_i & ~w_misalign;
   assign rdata_o = (w_final & ~mem_write_i & ~w_misalign) ? w_rd_data : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req && (LATENCY > 1)) begin
                  r_state <= ST_BUSY;
                  r_cnt   <= CNT_LOAD;
               end
            end
            ST_BUSY: begin
               // Dropping req mid-access is a flush: leave without committing.
               if (!w_req || (r_cnt == '0)) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk_i   (clk_i),
      .we_i    (w_we),
      .addr_i  (w_idx),
      .wdata_i (wdata_i),
      .rdata_o (w_rd_data)
   );

endmodule

// File: tb/tb_dmem_stage.sv
// Bench for dmem_stage: four instances (LATENCY 1..4) checked every cycle against a transaction-level model.
module tb_dmem_stage;

   localparam int NDUT  = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 32;
`ifdef DMEM_MISALIGN_CHECK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } pin_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          rd_s    [NDUT];
   logic          wr_s    [NDUT];
   logic [31:0]   addr_s  [NDUT];
   logic [DW-1:0] wdata_s [NDUT];
   logic [DW-1:0] rdata_s [NDUT];
   logic          stall_s [NDUT];
   logic          done_s  [NDUT];
   logic          err_s   [NDUT];

   logic          exp_stall [NDUT];
   logic          exp_done  [NDUT];
   logic          exp_err   [NDUT];
   logic [DW-1:0] exp_rdata [NDUT];
   logic [DW-1:0] ref_mem   [NDUT][DEPTH];

   bit   chk_en;
   pin_t pins[$];
   int   pin_rd;
   int   n_checks;
   int   n_pass;

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
         dmem_stage #(
            .DATA_W  (DW),
            .DEPTH   (DEPTH),
            .LATENCY (gi + 1)
         ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .mem_read_i  (rd_s[gi]),
            .mem_write_i (wr_s[gi]),
            .addr_i      (addr_s[gi]),
            .wdata_i     (wdata_s[gi]),
            .rdata_o     (rdata_s[gi]),
            .stall_o     (stall_s[gi]),
            .done_o      (done_s[gi]),
            .err_o       (err_s[gi])
         );
      end
   endgenerate

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endfunction

   // Single compare process: per-cycle model outputs for every instance, plus queued literal pins.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < NDUT; d++) begin
            check($sformatf("stall_L%0d", d + 1), {31'b0, stall_s[d]}, {31'b0, exp_stall[d]});
            check($sformatf("done_L%0d", d + 1),  {31'b0, done_s[d]},  {31'b0, exp_done[d]});
            check($sformatf("err_L%0d", d + 1),   {31'b0, err_s[d]},   {31'b0, exp_err[d]});
            check($sformatf("rdata_L%0d", d + 1), rdata_s[d], exp_rdata[d]);
         end
      end
      while (pin_rd < pins.size()) begin
         check(pins[pin_rd].name, pins[pin_rd].act, pins[pin_rd].exp);
         pin_rd++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      for (int d = 0; d < NDUT; d++) begin
         rd_s[d]      = 1'b0;
         wr_s[d]      = 1'b0;
         exp_stall[d] = 1'b0;
         exp_done[d]  = 1'b0;
         exp_err[d]   = 1'b0;
         exp_rdata[d] = '0;
      end
   endtask

   task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
      pin_t p;
      p.name = name;
      p.act  = act;
      p.exp  = exp;
      pins.push_back(p);
   endtask

   // One access on instance d, holding req for 'cycles' cycles (fewer than LATENCY means a flush).
   task automatic access(input int d, input bit w, input bit r, input logic [31:0] a,
                         input logic [DW-1:0] wd, input int cycles,
                         output int n_stall, output int n_done,
                         output logic [DW-1:0] fin_rdata, output logic fin_err);
      int lat;
      int idx;
      bit mis;
      lat       = d + 1;
      idx       = int'(a[6:2]);
      mis       = MIS_EN && (a[1:0] != 2'b00);
      n_stall   = 0;
      n_done    = 0;
      fin_rdata = '0;
      fin_err   = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         bit fin;
         fin          = (c == lat - 1);
         rd_s[d]      = r;
         wr_s[d]      = w;
         addr_s[d]    = a;
         wdata_s[d]   = wd;
         exp_stall[d] = !fin;
         exp_done[d]  = fin;
         exp_err[d]   = fin && mis;
         exp_rdata[d] = (fin && r && !w && !mis) ? ref_mem[d][idx] : '0;
         @(negedge clk);
         if (stall_s[d] === 1'b1) n_stall++;
         if (done_s[d] === 1'b1) begin
            n_done++;
            fin_rdata = rdata_s[d];
            fin_err   = err_s[d];
         end
         step();
         if (fin && w && !mis) ref_mem[d][idx] = wd;
      end
      idle_all();
      if (cycles < lat) step();
   endtask

   initial begin
      int            ns;
      int            nd;
      int            tot_s;
      int            tot_d;
      logic [DW-1:0] rdv;
      logic          erv;
      n_checks = 0;
      n_pass   = 0;
      pin_rd   = 0;
      chk_en   = 1'b0;
      rst      = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
         addr_s[d]  = '0;
         wdata_s[d] = '0;
      end
      idle_all();
      step();
      step();
      rst    = 1'b0;
      chk_en = 1'b1;
      step();

      // Give every word a known value.
      for (int d = 0; d < NDUT; d++) begin
         for (int i = 0; i < DEPTH; i++) begin
            access(d, 1'b1, 1'b0, 32'(i * 4), $urandom, d + 1, ns, nd, rdv, erv);
         end
      end

      // LATENCY=2 write then read
      access(1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 2, ns, nd, rdv, erv);
      pin("t1_wr_stall", 32'(ns), 32'd1);
      pin("t1_wr_done", 32'(nd), 32'd1);
      access(1, 1'b0, 1'b1, 32'h10, 32'h0, 2, ns, nd, rdv, erv);
      pin("t1_rd_stall", 32'(ns), 32'd1);
      pin("t1_rd_done", 32'(nd), 32'd1);
      pin("t1_rd_data", rdv, 32'hDEADBEEF);

      // LATENCY=1 back-to-back reads
      tot_s = 0;
      tot_d = 0;
      for (int k = 0; k < 3; k++) begin
         access(0, 1'b0, 1'b1, 32'(k * 4), 32'h0, 1, ns, nd, rdv, erv);
         tot_s += ns;
         tot_d += nd;
      end
      pin("t2_stall_total", 32'(tot_s), 32'd0);
      pin("t2_done_total", 32'(tot_d), 32'd3);

      // LATENCY=3 alias of 0x84 onto word 1
      access(2, 1'b1, 1'b0, 32'h84, 32'h5A5A1234, 3, ns, nd, rdv, erv);
      pin("t3_wr_stall", 32'(ns), 32'd2);
      access(2, 1'b0, 1'b1, 32'h04, 32'h0, 3, ns, nd, rdv, erv);
      pin("t3_rd_stall", 32'(ns), 32'd2);
      pin("t3_rd_data", rdv, 32'h5A5A1234);

      // LATENCY=4 flushed write leaves the old value
      access(3, 1'b1, 1'b0, 32'h20, 32'h11112222, 4, ns, nd, rdv, erv);
      access(3, 1'b1, 1'b0, 32'h20, 32'hCAFEF00D, 2, ns, nd, rdv, erv);
      pin("t4_flush_done", 32'(nd), 32'd0);
      access(3, 1'b0, 1'b1, 32'h20, 32'h0, 4, ns, nd, rdv, erv);
      pin("t4_rd_data", rdv, 32'h11112222);

      // Reset in the second cycle of a LATENCY=4 write
      access(3, 1'b1, 1'b0, 32'h24, 32'h33334444, 4, ns, nd, rdv, erv);
      wr_s[3]      = 1'b1;
      addr_s[3]    = 32'h24;
      wdata_s[3]   = 32'h99999999;
      exp_stall[3] = 1'b1;
      step();
      chk_en = 1'b0;
      rst    = 1'b1;
      step();
      rst    = 1'b0;
      idle_all();
      chk_en = 1'b1;
      @(negedge clk);
      pin("t5_stall_after_rst", {31'b0, stall_s[3]}, 32'd0);
      pin("t5_done_after_rst", {31'b0, done_s[3]}, 32'd0);
      step();
      access(3, 1'b0, 1'b1, 32'h24, 32'h0, 4, ns, nd, rdv, erv);
      pin("t5_rd_data", rdv, 32'h33334444);
      access(3, 1'b1, 1'b0, 32'h24, 32'h55556666, 4, ns, nd, rdv, erv);
      pin("t5_post_stall", 32'(ns), 32'd3);
      pin("t5_post_done", 32'(nd), 32'd1);

      // Misaligned write onto word 4 (holding 0xDEADBEEF on the LATENCY=2 instance)
      access(1, 1'b1, 1'b0, 32'h12, 32'h77778888, 2, ns, nd, rdv, erv);
      pin("t6_done", 32'(nd), 32'd1);
      pin("t6_err", {31'b0, erv}, MIS_EN ? 32'd1 : 32'd0);
      access(1, 1'b0, 1'b1, 32'h10, 32'h0, 2, ns, nd, rdv, erv);
      pin("t6_word4", rdv, MIS_EN ? 32'hDEADBEEF : 32'h77778888);

      // Randomized traffic across all instances
      for (int it = 0; it < 400; it++) begin
         int          d;
         int          op;
         int          cyc;
         logic [31:0] a;
         d = int'($urandom_range(0, NDUT - 1));
         op = int'($urandom_range(0, 4));
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         cyc = d + 1;
         case (op)
            0, 1:    access(d, 1'b0, 1'b1, a, $urandom, cyc, ns, nd, rdv, erv);
            2:       access(d, 1'b1, 1'b0, a, $urandom, cyc, ns, nd, rdv, erv);
            3:       access(d, 1'b1, 1'b1, a, $urandom, cyc, ns, nd, rdv, erv);
            default: begin
               if (d > 0) cyc = int'($urandom_range(1, d));
               access(d, $urandom_range(0, 1) == 1, 1'b1, a, $urandom, cyc, ns, nd, rdv, erv);
            end
         endcase
         if ($urandom_range(0, 2) == 0) step();
      end

      step();
      step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dmem_stage.md
# dmem_stage

Data-memory stage of the 5-stage pipeline, directly downstream of the EX/MEM register and feeding the MEM/WB register. It takes MemRead/MemWrite, ALU address and write data from EX/MEM. It performs a word access on an internal data memory with a configurable multi-cycle latency, and raises `stall_o` to the hazard unit until the access completes. Read data and a completion pulse are presented in the final access cycle so MEM/WB captures them on that edge.

## Interface
- `DATA_W`, 32, data word width
- `DEPTH`, 32, memory depth in words (power of 2)
- `LATENCY`, 2, cycles per access including the accept cycle (≥1)

Ports:
- `clk_i` in 1: single clock; everything on posedge
- `rst_i` in 1: reset, synchronous, active-high
- `mem_read_i` in 1: MemRead from EX/MEM M field
- `mem_write_i` in 1: MemWrite from EX/MEM M field
- `addr_i` in 32: byte address (EX/MEM ALU result)
- `wdata_i` in DATA_W: store data (EX/MEM forwarded rt value)
- `rdata_o` out DATA_W: load data to MEM/WB
- `stall_o` out 1: freeze PC, IF/ID, ID/EX, EX/MEM
- `done_o` out 1: access completes this cycle
- `err_o` out 1: misaligned access (see Configuration)

## Operation
- Request: `req = mem_read_i | mem_write_i`. Both high means a write; the read is ignored.
- Word index = `addr_i[2 +: log2(DEPTH)]`. Upper bits are ignored, so out-of-range addresses alias and wrap modulo DEPTH.
- FSM states:
  - IDLE → BUSY when `req` and LATENCY>1. Counter loads LATENCY-2.
  - BUSY with counter≠0: decrement.
  - BUSY with counter==0: final cycle; → IDLE.
  - LATENCY==1: every `req` cycle in IDLE is a final cycle; no BUSY.
- Final cycle:
  - `done_o`=1 and `stall_o`=0.
  - Reads: `rdata_o` = mem[index], combinational.
  - Writes: mem[index] ← `wdata_i` at the closing edge.
- Non-final cycles of an access: `stall_o`=1, `done_o`=0, `rdata_o`=0.
- Upstream holds inputs stable while `stall_o`=1.
- `req` dropping while BUSY (flush): abort, → IDLE next edge, no write, no `done_o`.
- No `req` in IDLE: all outputs 0, state unchanged.
- Back-to-back: the cycle after a final cycle is IDLE and accepts a new `req` immediately. There is no bubble.

## Timing
- Reset values: state IDLE, counter 0, `stall_o`/`done_o`/`err_o`/`rdata_o` = 0. Memory contents are not cleared.
- Reset mid-access aborts the access. No write is committed and outputs are 0 the cycle after the reset edge.
- Latency:
  - An access accepted in cycle t completes in cycle t+LATENCY-1.
  - `stall_o` is high for cycles t..t+LATENCY-2 (LATENCY-1 cycles).
  - `stall_o` is combinational from state, counter and `req`.
- The write commits exactly once, on the final-cycle edge.
- Read data is valid only while `done_o`=1.

## Configuration
- `DMEM_MISALIGN_CHECK_EN` defined:
  - `addr_i[1:0]`≠0 on a request asserts `err_o` in the final cycle, alongside `done_o`.
  - The write is suppressed and `rdata_o`=0.
  - Timing and stall behaviour are unchanged.
- Not defined: `addr_i[1:0]` is ignored and `err_o` is tied 0.

## Structure
- Package `dmem_pkg`:
  - FSM state enum (IDLE, BUSY).
  - Default DATA_W/DEPTH/LATENCY constants.
  - Counter-width function (clog2 of LATENCY).
- Sub-module `dmem_array`: DEPTH×DATA_W storage, combinational read port, synchronous write port with write enable.
- `dmem_stage` holds the FSM, counter, address decode and error check.

## Test plan
- LATENCY=2, write 0xDEADBEEF @0x10, then read @0x10 → `stall_o` 1 for 1 cycle each; read-final cycle `rdata_o`=0xDEADBEEF, `done_o`=1.
- LATENCY=1, reads back-to-back @0x0, 0x4, 0x8 → `stall_o` never high, `done_o` high 3 consecutive cycles.
- LATENCY=3, write @0x84 with DEPTH=32 → aliases to word 1; read @0x04 returns the data; `stall_o` high 2 cycles.
- LATENCY=4, write accepted, `req` dropped in second cycle → no `done_o`; subsequent read of that word returns the old value.
- `rst_i` pulsed mid-write → outputs 0 the next cycle, memory unchanged, next request accepted normally.
- With `DMEM_MISALIGN_CHECK_EN`, write @0x12 → `err_o`=1 with `done_o` in the final cycle; word 4 unchanged. Without the macro, the same write stores to word 4 and `err_o`=0.
